// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST types and SRAM geometry
package bist_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 4;
  localparam int SRAM_DEPTH  = 256;
  // Read sweeps per complete test; the BIST counter uses the same value.
  localparam int READ_PASSES = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/bist_response_checker_if.sv
// rtl/bist_response_checker_if.sv - BIST stimulus/SRAM read side and result bus of the response checker
interface bist_response_checker_if
  import bist_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ERR_W  = 9
);

  logic              bist_we;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_exp;
  logic [DATA_W-1:0] sram_rdata;

  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_rdata;
  logic [DATA_W-1:0] fail_exp;
  logic              fail_seen;

  modport master (
    output bist_we, bist_addr, bist_exp, sram_rdata,
    input  busy, done, pass, err_count, fail_addr, fail_rdata, fail_exp, fail_seen
  );

  modport slave (
    input  bist_we, bist_addr, bist_exp, sram_rdata,
    output busy, done, pass, err_count, fail_addr, fail_rdata, fail_exp, fail_seen
  );

endinterface

// File: rtl/bist_exp_delay.sv
// rtl/bist_exp_delay.sv - RD_LAT-deep shift register aligning {valid, addr, exp} with SRAM read data
module bist_exp_delay
  import bist_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] exp_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
      end
      valid_q[0] <= valid_i;
    end
  end

  // Payload is only meaningful alongside its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      addr_q[i] <= addr_q[i-1];
      exp_q[i]  <= exp_q[i-1];
    end
    addr_q[0] <= addr_i;
    exp_q[0]  <= exp_i;
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign addr_o  = addr_q[RD_LAT-1];
  assign exp_o   = exp_q[RD_LAT-1];

endmodule

// File: rtl/bist_response_checker.sv
// rtl/bist_response_checker.sv - BIST response analyser: delay-matched compare, error count, first-failure capture
module bist_response_checker
  import bist_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int RD_LAT        = 1,
  parameter int ERR_W         = 9,
  parameter int N_READ_PASSES = READ_PASSES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  bist_response_checker_if.slave bus
);

  localparam int CNT_W = ADDR_W + $clog2(N_READ_PASSES) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(N_READ_PASSES * (2 ** ADDR_W));
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_rdata_q, fail_rdata_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic              fail_seen_q, fail_seen_d;
  logic              pass_q, pass_d;

  logic              start_acc;
  logic              dl_valid;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_exp;

  // A start in RUN is dropped; from IDLE or DONE it also flushes the delay line.
  assign start_acc = start && (state_q != RUN);

  bist_exp_delay #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_exp_delay (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_acc),
    .valid_i (~bus.bist_we),
    .addr_i  (bus.bist_addr),
    .exp_i   (bus.bist_exp),
    .valid_o (dl_valid),
    .addr_o  (dl_addr),
    .exp_o   (dl_exp)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_addr_d  = fail_addr_q;
    fail_rdata_d = fail_rdata_q;
    fail_exp_d   = fail_exp_q;
    fail_seen_d  = fail_seen_q;
    pass_d       = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          cnt_d        = '0;
          err_d        = '0;
          fail_addr_d  = '0;
          fail_rdata_d = '0;
          fail_exp_d   = '0;
          fail_seen_d  = 1'b0;
          pass_d       = 1'b0;
        end
      end
      RUN: begin
        if (dl_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (bus.sram_rdata != dl_exp) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            if (!fail_seen_q) begin
              fail_addr_d  = dl_addr;
              fail_rdata_d = bus.sram_rdata;
              fail_exp_d   = dl_exp;
              fail_seen_d  = 1'b1;
            end
          end
          // The terminal compare is already folded into err_d here.
          if (cnt_d == CNT_TERM) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_addr_q  <= '0;
      fail_rdata_q <= '0;
      fail_exp_q   <= '0;
      fail_seen_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_addr_q  <= fail_addr_d;
      fail_rdata_q <= fail_rdata_d;
      fail_exp_q   <= fail_exp_d;
      fail_seen_q  <= fail_seen_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_rdata = fail_rdata_q;
  assign bus.fail_exp   = fail_exp_q;
  assign bus.fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_bist_response_checker.sv
// tb/tb_bist_response_checker.sv - bench for bist_response_checker: RD_LAT=1/ERR_W=9 and RD_LAT=3/ERR_W=4 instances on one BIST stream
module tb_bist_response_checker;
  import bist_pkg::*;

  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;
  localparam int ERRW_A = 9;
  localparam int ERRW_B = 4;
  localparam int N_CMP  = READ_PASSES * SRAM_DEPTH;

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] exp;
    logic [3:0] rdata;
  } rd_t;

  // Fault modes: 0 none, 1 rdata[2] stuck-0 at 0x3C, 2 flip at 0xFF in last pass,
  // 3 every read inverted, 4 sparse random flips, 5 flip at 0x10 in pass 0.
  typedef struct {
    int mode_a;
    int mode_b;
    int mid_start;
    int err_a;
    int err_b;
    int faddr_a;
    int faddr_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   mode_a, mode_b, done_cyc_a, done_cyc_b, last_cyc;
  logic pend_start;
  logic [3:0] mem [SRAM_DEPTH];
  logic [3:0] pat [READ_PASSES][SRAM_DEPTH];
  logic [3:0] hist_a [8];
  logic [3:0] hist_b [8];
  rd_t  rd_a [$];
  rd_t  rd_b [$];
  vec_t vecs [3];

  bist_response_checker_if #(.ADDR_W(SRAM_ADDR_W), .DATA_W(SRAM_DATA_W), .ERR_W(ERRW_A)) if_a ();
  bist_response_checker_if #(.ADDR_W(SRAM_ADDR_W), .DATA_W(SRAM_DATA_W), .ERR_W(ERRW_B)) if_b ();

  bist_response_checker #(.RD_LAT(LAT_A), .ERR_W(ERRW_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .bus(if_a.slave));
  bist_response_checker #(.RD_LAT(LAT_B), .ERR_W(ERRW_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .bus(if_b.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [3:0] corrupt(input int mode, input logic [3:0] d,
                                         input logic [7:0] a, input int p);
    case (mode)
      1:       return (a == 8'h3C) ? (d & 4'b1011) : d;
      2:       return (a == 8'hFF && p == READ_PASSES - 1) ? ~d : d;
      3:       return ~d;
      4:       return ($urandom_range(0, 31) == 0) ? d ^ 4'($urandom_range(1, 15)) : d;
      5:       return (a == 8'h10 && p == 0) ? ~d : d;
      default: return d;
    endcase
  endfunction

  // One clock: sample done edges, then present this cycle's BIST inputs and delayed SRAM data.
  task automatic step(input logic we, input logic [7:0] addr, input logic [3:0] exp, input int p);
    logic [3:0] da, db;
    rd_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (if_a.done && done_cyc_a < 0) done_cyc_a = cyc;
    if (if_b.done && done_cyc_b < 0) done_cyc_b = cyc;
    for (int i = 7; i > 0; i--) begin
      hist_a[i] = hist_a[i-1];
      hist_b[i] = hist_b[i-1];
    end
    da = 4'($urandom);
    db = 4'($urandom);
    if (we) begin
      mem[addr] = exp;
    end else begin
      da = corrupt(mode_a, mem[addr], addr, p);
      db = corrupt(mode_b, mem[addr], addr, p);
      r.addr = addr; r.exp = exp; r.rdata = da;
      rd_a.push_back(r);
      r.rdata = db;
      rd_b.push_back(r);
      if (rd_a.size() == N_CMP) last_cyc = cyc;
    end
    hist_a[0] = da;
    hist_b[0] = db;
    start = pend_start;
    pend_start = 1'b0;
    if_a.bist_we = we; if_a.bist_addr = addr; if_a.bist_exp = exp; if_a.sram_rdata = hist_a[LAT_A];
    if_b.bist_we = we; if_b.bist_addr = addr; if_b.bist_exp = exp; if_b.sram_rdata = hist_b[LAT_B];
  endtask

  task automatic kick(input int ma, input int mb);
    mode_a = ma;
    mode_b = mb;
    for (int p = 0; p < READ_PASSES; p++)
      for (int a = 0; a < SRAM_DEPTH; a++) pat[p][a] = 4'($urandom);
    if (ma == 1)
      for (int p = 0; p < READ_PASSES; p++) pat[p][8'h3C][2] = 1'b1;
    rd_a.delete();
    rd_b.delete();
    last_cyc = -1;
    pend_start = 1'b1;
    step(1'b1, 8'h00, pat[0][0], 0);
    done_cyc_a = -1;
    done_cyc_b = -1;
  endtask

  task automatic run_pattern(input int max_reads, input int mid_start);
    int r;
    for (int p = 0; p < READ_PASSES; p++) begin
      for (int a = 0; a < SRAM_DEPTH; a++) step(1'b1, 8'(a), pat[p][a], p);
      for (int a = 0; a < SRAM_DEPTH; a++) begin
        while ($urandom_range(0, 7) == 0) begin
          r = $urandom_range(0, SRAM_DEPTH - 1);
          step(1'b1, 8'(r), pat[p][r], p);
        end
        if (rd_a.size() == max_reads) return;
        if (rd_a.size() == mid_start) pend_start = 1'b1;
        step(1'b0, 8'(a), pat[p][a], p);
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom), 8'($urandom), 4'($urandom), 0);
  endtask

  // Reference: outcome of the first N_CMP reads, judged from the recorded read list.
  task automatic check_model(input string tag, input rd_t q[$], input int errw, input int lat,
                             input int done_cyc, input logic busy, input logic done,
                             input logic pass, input logic fseen, input int err,
                             input logic [7:0] faddr, input logic [3:0] frd, input logic [3:0] fexp);
    int nerr;
    int first;
    int emax;
    nerr = 0;
    first = -1;
    emax = (1 << errw) - 1;
    for (int i = 0; i < N_CMP && i < q.size(); i++) begin
      if (q[i].rdata != q[i].exp) begin
        nerr++;
        if (first < 0) first = i;
      end
    end
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 1);
    check({tag, " pass"}, pass, nerr == 0);
    check({tag, " err_count"}, err, (nerr > emax) ? emax : nerr);
    check({tag, " fail_seen"}, fseen, first >= 0);
    if (first >= 0) begin
      check({tag, " fail_addr"}, faddr, q[first].addr);
      check({tag, " fail_rdata"}, frd, q[first].rdata);
      check({tag, " fail_exp"}, fexp, q[first].exp);
    end else begin
      check({tag, " fail regs"}, {faddr, frd, fexp}, 0);
    end
    check({tag, " done_latency"}, done_cyc - last_cyc, lat + 1);
  endtask

  task automatic check_a(input string tag);
    check_model({tag, " a"}, rd_a, ERRW_A, LAT_A, done_cyc_a, if_a.busy, if_a.done, if_a.pass,
                if_a.fail_seen, int'(if_a.err_count), if_a.fail_addr, if_a.fail_rdata, if_a.fail_exp);
  endtask

  task automatic check_b(input string tag);
    check_model({tag, " b"}, rd_b, ERRW_B, LAT_B, done_cyc_b, if_b.busy, if_b.done, if_b.pass,
                if_b.fail_seen, int'(if_b.err_count), if_b.fail_addr, if_b.fail_rdata, if_b.fail_exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a flags"}, {if_a.busy, if_a.done, if_a.pass, if_a.fail_seen}, 0);
    check({tag, " a err_count"}, if_a.err_count, 0);
    check({tag, " a fail regs"}, {if_a.fail_addr, if_a.fail_rdata, if_a.fail_exp}, 0);
    check({tag, " b flags"}, {if_b.busy, if_b.done, if_b.pass, if_b.fail_seen}, 0);
    check({tag, " b err_count"}, if_b.err_count, 0);
    check({tag, " b fail regs"}, {if_b.fail_addr, if_b.fail_rdata, if_b.fail_exp}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0, -1, 0, 0, -1, -1};
    vecs[1] = '{1, 2, -1, 2, 1, 'h3C, 'hFF};
    vecs[2] = '{4, 3, 200, -1, 15, -1, 'h00};

    rst = 1'b1;
    start = 1'b0;
    pend_start = 1'b0;
    mode_a = 0;
    mode_b = 0;
    done_cyc_a = -1;
    done_cyc_b = -1;
    last_cyc = -1;
    foreach (hist_a[i]) hist_a[i] = '0;
    foreach (hist_b[i]) hist_b[i] = '0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) step(1'b1, 8'h00, 4'h0, 0);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      kick(vecs[i].mode_a, vecs[i].mode_b);
      run_pattern(N_CMP, vecs[i].mid_start);
      drain(12);
      check_a($sformatf("vec%0d", i));
      check_b($sformatf("vec%0d", i));
      if (vecs[i].err_a >= 0)   check($sformatf("vec%0d a fixed err", i), if_a.err_count, vecs[i].err_a);
      if (vecs[i].err_b >= 0)   check($sformatf("vec%0d b fixed err", i), if_b.err_count, vecs[i].err_b);
      if (vecs[i].faddr_a >= 0) check($sformatf("vec%0d a fixed addr", i), if_a.fail_addr, vecs[i].faddr_a);
      if (vecs[i].faddr_b >= 0) check($sformatf("vec%0d b fixed addr", i), if_b.fail_addr, vecs[i].faddr_b);
    end

    drain(20);
    check_a("done_hold");
    check_b("done_hold");

    kick(0, 0);
    step(1'b1, 8'h00, pat[0][0], 0);
    check("restart a busy", if_a.busy, 1);
    check("restart a done", if_a.done, 0);
    check("restart a err_count", if_a.err_count, 0);
    check("restart b err_count", if_b.err_count, 0);
    check("restart b fail_seen", if_b.fail_seen, 0);
    run_pattern(N_CMP, -1);
    drain(12);
    check_a("restart");
    check_b("restart");

    kick(5, 0);
    run_pattern(100, -1);
    repeat (LAT_B + 2) step(1'b1, 8'h00, pat[0][0], 0);
    check("midrun a busy", if_a.busy, 1);
    check("midrun a err_count", if_a.err_count, 1);
    check("midrun a fail_addr", if_a.fail_addr, 8'h10);
    rst = 1'b1;
    step(1'b1, 8'h00, pat[0][0], 0);
    check_zero("midrun_rst");
    rst = 1'b0;
    repeat (3) step(1'b0, 8'h00, pat[0][0], 0);
    check_zero("post_rst_idle");

    kick(0, 0);
    run_pattern(N_CMP, -1);
    drain(12);
    check_a("after_rst");
    check_b("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
